// File: rtl/drop_controller.sv
// Drop controller: waits for four stable sensor readings, computes a height,
// then either rejects the measurement or drives the drop actuator for t_act cycles.

module sensors_input (
  input  logic [7:0] sensor1,
  input  logic [7:0] sensor2,
  input  logic [7:0] sensor3,
  input  logic [7:0] sensor4,
  output logic [7:0] height
);

  localparam int unsigned SUM_W = 10;

  logic [SUM_W-1:0] sum_24;
  logic [SUM_W-1:0] sum_13;
  logic [SUM_W-1:0] sum_all;

  // A zero reading marks a sensor pair as faulty; average the other pair instead.
  always_comb begin
    sum_24  = SUM_W'(sensor2) + SUM_W'(sensor4);
    sum_13  = SUM_W'(sensor1) + SUM_W'(sensor3);
    sum_all = SUM_W'(sensor1) + SUM_W'(sensor2) + SUM_W'(sensor3) + SUM_W'(sensor4);
    if (sensor1 == 8'd0 || sensor3 == 8'd0) begin
      height = 8'((sum_24 + SUM_W'(sum_24[0])) >> 1);
    end else if (sensor2 == 8'd0 || sensor4 == 8'd0) begin
      height = 8'((sum_13 + SUM_W'(sum_13[0])) >> 1);
    end else begin
      height = 8'((sum_all + {{(SUM_W-2){1'b0}}, sum_all[1], 1'b0}) >> 2);
    end
  end

endmodule

module drop_controller #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter logic [7:0]  MAX_HEIGHT    = 8'd100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sensor1,
  input  logic [7:0]  sensor2,
  input  logic [7:0]  sensor3,
  input  logic [7:0]  sensor4,
  input  logic        drop_req,
  input  logic        abort,
  input  logic [15:0] t_act,
  output logic [7:0]  height,
  output logic        drop_activated,
  output logic        busy,
  output logic        done,
  output logic        reject
);

  localparam int unsigned SENS_W = 8;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned TACT_W = 16;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STABLE,
    S_CHECK,
    S_DROP,
    S_DONE,
    S_REJECT
  } state_t;

  state_t                   state_q, state_d;
  logic [3:0][SENS_W-1:0]   lat_q, lat_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [TACT_W-1:0]        drop_cnt_q, drop_cnt_d;
  logic [SENS_W-1:0]        height_q, height_d;
  logic                     drop_act_q, drop_act_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     reject_q, reject_d;

  logic [3:0][SENS_W-1:0]   sens_now;
  logic [SENS_W-1:0]        calc_height;
  logic                     sens_diff;

  assign sens_now  = {sensor4, sensor3, sensor2, sensor1};
  assign sens_diff = (sens_now != lat_q);

  sensors_input u_sensors (
    .sensor1 (lat_q[0]),
    .sensor2 (lat_q[1]),
    .sensor3 (lat_q[2]),
    .sensor4 (lat_q[3]),
    .height  (calc_height)
  );

  // Next-state, datapath and Moore outputs decoded from the next state.
  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    cnt_d      = cnt_q;
    drop_cnt_d = drop_cnt_q;
    height_d   = height_q;

    unique case (state_q)
      S_IDLE: begin
        if (drop_req && !abort) begin
          lat_d   = sens_now;
          cnt_d   = '0;
          state_d = S_STABLE;
        end
      end
      S_STABLE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (sens_diff) begin
          lat_d = sens_now;
          cnt_d = '0;
        end else if (cnt_q == LAST_CNT) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CHECK: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          height_d = calc_height;
          if (calc_height == 8'd0 || calc_height > MAX_HEIGHT) begin
            state_d = S_REJECT;
          end else begin
            drop_cnt_d = (t_act == 16'd0) ? 16'd1 : t_act;
            state_d    = S_DROP;
          end
        end
      end
      S_DROP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (drop_cnt_q <= 16'd1) begin
          drop_cnt_d = '0;
          state_d    = S_DONE;
        end else begin
          drop_cnt_d = drop_cnt_q - TACT_W'(1);
        end
      end
      S_DONE:   state_d = S_IDLE;
      S_REJECT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    busy_d     = (state_d != S_IDLE);
    drop_act_d = (state_d == S_DROP);
    done_d     = (state_d == S_DONE);
    reject_d   = (state_d == S_REJECT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lat_q      <= '0;
      cnt_q      <= '0;
      drop_cnt_q <= '0;
      height_q   <= '0;
      drop_act_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      reject_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      cnt_q      <= cnt_d;
      drop_cnt_q <= drop_cnt_d;
      height_q   <= height_d;
      drop_act_q <= drop_act_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      reject_q   <= reject_d;
    end
  end

  assign height         = height_q;
  assign drop_activated = drop_act_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign reject         = reject_q;

endmodule
